// File: rtl/cache_pkg.sv
// Shared types and width helpers for the cache sequencing controller.
package cache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StCompare,
        StWriteback,
        StRefill,
        StUpdate,
        StResp
    } ctrl_state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned off_width(input int unsigned line_size);
        return clog2_min1(line_size);
    endfunction

    function automatic int unsigned set_width(input int unsigned num_sets);
        return clog2_min1(num_sets);
    endfunction

    function automatic int unsigned way_width(input int unsigned assoc);
        return clog2_min1(assoc);
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned num_sets,
                                              input int unsigned line_size);
        return addr_w - set_width(num_sets) - off_width(line_size);
    endfunction

    // Line-aligned byte address {tag, index, zero offset}; caller truncates.
    function automatic logic [63:0] line_addr(input logic [63:0] tag,
                                              input logic [63:0] index,
                                              input int unsigned set_w,
                                              input int unsigned off_w);
        return (tag << (set_w + off_w)) | (index << off_w);
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU, tag-array, data-array and memory signals of the cache controller.
interface cache_ctrl_if #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned LINE_SIZE     = 64,
    parameter int unsigned NUM_SETS      = 64,
    parameter int unsigned ASSOCIATIVITY = 4
);
    import cache_pkg::*;

    localparam int unsigned SetW = set_width(NUM_SETS);
    localparam int unsigned WayW = way_width(ASSOCIATIVITY);
    localparam int unsigned TagW = tag_width(ADDR_WIDTH, NUM_SETS, LINE_SIZE);

    logic                  cpu_req_valid;
    logic                  cpu_req_ready;
    logic                  cpu_req_we;
    logic [ADDR_WIDTH-1:0] cpu_req_addr;
    logic                  cpu_resp_valid;
    logic                  cpu_resp_hit;

    logic                  tag_rd_en;
    logic                  tag_wr_en;
    logic                  tag_wr_dirty;
    logic [SetW-1:0]       tag_index;
    logic [TagW-1:0]       tag_tag;
    logic [WayW-1:0]       tag_way;
    logic                  tag_hit;
    logic [WayW-1:0]       tag_hit_way;
    logic                  tag_victim_dirty;
    logic [TagW-1:0]       tag_victim_tag;

    logic                  data_we;
    logic                  data_fill;
    logic [SetW-1:0]       data_index;
    logic [WayW-1:0]       data_way;

    logic                  mem_req_valid;
    logic                  mem_req_we;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_ack;

    modport master (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_hit,
        output tag_rd_en, tag_wr_en, tag_wr_dirty, tag_index, tag_tag, tag_way,
        input  tag_hit, tag_hit_way, tag_victim_dirty, tag_victim_tag,
        output data_we, data_fill, data_index, data_way,
        output mem_req_valid, mem_req_we, mem_req_addr,
        input  mem_req_ack
    );

    modport slave (
        output cpu_req_valid, cpu_req_we, cpu_req_addr,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_hit,
        input  tag_rd_en, tag_wr_en, tag_wr_dirty, tag_index, tag_tag, tag_way,
        output tag_hit, tag_hit_way, tag_victim_dirty, tag_victim_tag,
        input  data_we, data_fill, data_index, data_way,
        input  mem_req_valid, mem_req_we, mem_req_addr,
        output mem_req_ack
    );

endinterface

// File: rtl/cache_repl.sv
// Per-set replacement state: tree pseudo-LRU with CACHE_CTRL_PLRU_EN, else round-robin.
module cache_repl
    import cache_pkg::*;
#(
    parameter int unsigned NUM_SETS      = 64,
    parameter int unsigned ASSOCIATIVITY = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [set_width(NUM_SETS)-1:0]        set_i,
    input  logic                                  touch_i,
    input  logic [way_width(ASSOCIATIVITY)-1:0]   touch_way_i,
    output logic [way_width(ASSOCIATIVITY)-1:0]   victim_o
);
    localparam int unsigned WayW = way_width(ASSOCIATIVITY);

`ifdef CACHE_CTRL_PLRU_EN
    localparam int unsigned NodeN = ASSOCIATIVITY - 1;

    // Heap-ordered tree: node n (root = 1) lives in bit n-1; 0 points toward lower ways.
    logic [NodeN-1:0] tree_q [NUM_SETS];
    logic [NodeN-1:0] cur, tree_d;

    always_comb begin
        int unsigned node;
        logic        b;
        cur  = tree_q[set_i];
        node = 1;
        b    = 1'b0;
        for (int l = 0; l < WayW; l++) begin
            b = 1'b0;
            for (int n = 1; n < ASSOCIATIVITY; n++) if (node == n) b = cur[n-1];
            node = 2 * node + (b ? 1 : 0);
        end
        victim_o = WayW'(node - ASSOCIATIVITY);

        tree_d = cur;
        node   = 1;
        for (int l = 0; l < WayW; l++) begin
            b = touch_way_i[WayW-1-l];
            for (int n = 1; n < ASSOCIATIVITY; n++) if (node == n) tree_d[n-1] = ~b;
            node = 2 * node + (b ? 1 : 0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) tree_q[s] <= '0;
        end else if (touch_i) begin
            tree_q[set_i] <= tree_d;
        end
    end
`else
    logic [WayW-1:0] cnt_q [NUM_SETS];
    logic            unused_touch_way;

    assign unused_touch_way = ^touch_way_i;
    assign victim_o         = cnt_q[set_i];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) cnt_q[s] <= '0;
        end else if (touch_i) begin
            cnt_q[set_i] <= cnt_q[set_i] + WayW'(1);
        end
    end
`endif

endmodule

// File: rtl/cache_ctrl.sv
// Set-associative cache sequencer: lookup, writeback, refill, tag update, response.
// Replacement policy selected by CACHE_CTRL_PLRU_EN (tree PLRU) else round-robin.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned LINE_SIZE     = 64,
    parameter int unsigned NUM_SETS      = 64,
    parameter int unsigned ASSOCIATIVITY = 4
) (
    input logic          clk,
    input logic          rst_n,
    cache_ctrl_if.master bus
);
    localparam int unsigned OffW = off_width(LINE_SIZE);
    localparam int unsigned SetW = set_width(NUM_SETS);
    localparam int unsigned WayW = way_width(ASSOCIATIVITY);
    localparam int unsigned TagW = tag_width(ADDR_WIDTH, NUM_SETS, LINE_SIZE);

`ifdef CACHE_CTRL_PLRU_EN
    localparam bit TouchOnHit = 1'b1;
`else
    localparam bit TouchOnHit = 1'b0;
`endif

    ctrl_state_e           state_q, state_d;
    logic [TagW-1:0]       req_tag_q, req_tag_d, vic_tag_q, vic_tag_d;
    logic [SetW-1:0]       req_idx_q, req_idx_d;
    logic [WayW-1:0]       victim_q, victim_d;
    logic                  req_we_q, req_we_d, hit_q, hit_d;

    // Last driven values of the address-like outputs, held while idle.
    logic [SetW-1:0]       tag_index_q, data_index_q;
    logic [TagW-1:0]       tag_tag_q;
    logic [WayW-1:0]       tag_way_q, data_way_q;
    logic                  tag_wr_dirty_q, data_fill_q, mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;

    logic [SetW-1:0]       cpu_idx, repl_set;
    logic [TagW-1:0]       cpu_tag;
    logic                  repl_touch, unused_off;
    logic [WayW-1:0]       repl_touch_way, repl_victim;

    assign cpu_idx    = bus.cpu_req_addr[OffW +: SetW];
    assign cpu_tag    = bus.cpu_req_addr[OffW+SetW +: TagW];
    assign unused_off = ^bus.cpu_req_addr[OffW-1:0];
    assign repl_set   = (state_q == StIdle) ? cpu_idx : req_idx_q;

    cache_repl #(
        .NUM_SETS      (NUM_SETS),
        .ASSOCIATIVITY (ASSOCIATIVITY)
    ) u_repl (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_i       (repl_set),
        .touch_i     (repl_touch),
        .touch_way_i (repl_touch_way),
        .victim_o    (repl_victim)
    );

    always_comb begin
        state_d   = state_q;
        req_tag_d = req_tag_q;
        req_idx_d = req_idx_q;
        req_we_d  = req_we_q;
        victim_d  = victim_q;
        vic_tag_d = vic_tag_q;
        hit_d     = hit_q;

        bus.cpu_req_ready  = 1'b0;
        bus.cpu_resp_valid = 1'b0;
        bus.cpu_resp_hit   = 1'b0;
        bus.tag_rd_en      = 1'b0;
        bus.tag_wr_en      = 1'b0;
        bus.tag_wr_dirty   = tag_wr_dirty_q;
        bus.tag_index      = tag_index_q;
        bus.tag_tag        = tag_tag_q;
        bus.tag_way        = tag_way_q;
        bus.data_we        = 1'b0;
        bus.data_fill      = data_fill_q;
        bus.data_index     = data_index_q;
        bus.data_way       = data_way_q;
        bus.mem_req_valid  = 1'b0;
        bus.mem_req_we     = mem_we_q;
        bus.mem_req_addr   = mem_addr_q;
        repl_touch         = 1'b0;
        repl_touch_way     = victim_q;

        unique case (state_q)
            StIdle: begin
                bus.cpu_req_ready = 1'b1;
                if (bus.cpu_req_valid) begin
                    req_tag_d = cpu_tag;
                    req_idx_d = cpu_idx;
                    req_we_d  = bus.cpu_req_we;
                    victim_d  = repl_victim;
                    state_d   = StLookup;
                end
            end
            StLookup: begin
                bus.tag_rd_en = 1'b1;
                bus.tag_index = req_idx_q;
                bus.tag_tag   = req_tag_q;
                bus.tag_way   = victim_q;
                state_d       = StCompare;
            end
            StCompare: begin
                if (bus.tag_hit) begin
                    hit_d          = 1'b1;
                    repl_touch     = TouchOnHit;
                    repl_touch_way = bus.tag_hit_way;
                    if (req_we_q) begin
                        bus.tag_wr_en    = 1'b1;
                        bus.tag_wr_dirty = 1'b1;
                        bus.tag_index    = req_idx_q;
                        bus.tag_tag      = req_tag_q;
                        bus.tag_way      = bus.tag_hit_way;
                        bus.data_we      = 1'b1;
                        bus.data_fill    = 1'b0;
                        bus.data_index   = req_idx_q;
                        bus.data_way     = bus.tag_hit_way;
                    end
                    state_d = StResp;
                end else begin
                    hit_d     = 1'b0;
                    vic_tag_d = bus.tag_victim_tag;
                    state_d   = bus.tag_victim_dirty ? StWriteback : StRefill;
                end
            end
            StWriteback: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_we    = 1'b1;
                bus.mem_req_addr  = ADDR_WIDTH'(line_addr(64'(vic_tag_q), 64'(req_idx_q),
                                                          SetW, OffW));
                if (bus.mem_req_ack) state_d = StRefill;
            end
            StRefill: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_we    = 1'b0;
                bus.mem_req_addr  = ADDR_WIDTH'(line_addr(64'(req_tag_q), 64'(req_idx_q),
                                                          SetW, OffW));
                if (bus.mem_req_ack) begin
                    bus.data_we    = 1'b1;
                    bus.data_fill  = 1'b1;
                    bus.data_index = req_idx_q;
                    bus.data_way   = victim_q;
                    state_d        = StUpdate;
                end
            end
            StUpdate: begin
                bus.tag_wr_en    = 1'b1;
                bus.tag_wr_dirty = req_we_q;
                bus.tag_index    = req_idx_q;
                bus.tag_tag      = req_tag_q;
                bus.tag_way      = victim_q;
                if (req_we_q) begin
                    bus.data_we    = 1'b1;
                    bus.data_fill  = 1'b0;
                    bus.data_index = req_idx_q;
                    bus.data_way   = victim_q;
                end
                repl_touch     = 1'b1;
                repl_touch_way = victim_q;
                state_d        = StResp;
            end
            StResp: begin
                bus.cpu_resp_valid = 1'b1;
                bus.cpu_resp_hit   = hit_q;
                state_d            = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Reset silences every strobe in the same cycle, abandoning any request.
        if (!rst_n) begin
            bus.cpu_req_ready  = 1'b0;
            bus.cpu_resp_valid = 1'b0;
            bus.cpu_resp_hit   = 1'b0;
            bus.tag_rd_en      = 1'b0;
            bus.tag_wr_en      = 1'b0;
            bus.data_we        = 1'b0;
            bus.mem_req_valid  = 1'b0;
            repl_touch         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            req_tag_q      <= '0;
            req_idx_q      <= '0;
            req_we_q       <= 1'b0;
            victim_q       <= '0;
            vic_tag_q      <= '0;
            hit_q          <= 1'b0;
            tag_index_q    <= '0;
            tag_tag_q      <= '0;
            tag_way_q      <= '0;
            tag_wr_dirty_q <= 1'b0;
            data_index_q   <= '0;
            data_way_q     <= '0;
            data_fill_q    <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
        end else begin
            state_q        <= state_d;
            req_tag_q      <= req_tag_d;
            req_idx_q      <= req_idx_d;
            req_we_q       <= req_we_d;
            victim_q       <= victim_d;
            vic_tag_q      <= vic_tag_d;
            hit_q          <= hit_d;
            tag_index_q    <= bus.tag_index;
            tag_tag_q      <= bus.tag_tag;
            tag_way_q      <= bus.tag_way;
            tag_wr_dirty_q <= bus.tag_wr_dirty;
            data_index_q   <= bus.data_index;
            data_way_q     <= bus.data_way;
            data_fill_q    <= bus.data_fill;
            mem_we_q       <= bus.mem_req_we;
            mem_addr_q     <= bus.mem_req_addr;
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl; victim expectations follow CACHE_CTRL_PLRU_EN.
`define CHK(ta, tb_, got, exp) \
    begin \
        checks++; \
        assert (64'(got) === 64'(exp)) else begin \
            failures++; \
            $error("FAIL %s%s got=%0h exp=%0h", ta, tb_, 64'(got), 64'(exp)); \
        end \
    end

module tb_cache_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [1:0] fill_way [4];
    logic [1:0] final_way;

    always #5 clk = ~clk;

    cache_ctrl_if #(
        .ADDR_WIDTH    (32),
        .LINE_SIZE     (64),
        .NUM_SETS      (64),
        .ASSOCIATIVITY (4)
    ) bus ();

    cache_ctrl #(
        .ADDR_WIDTH    (32),
        .LINE_SIZE     (64),
        .NUM_SETS      (64),
        .ASSOCIATIVITY (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Sample point is 2 time units after the rising edge; ack is a one-cycle pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.mem_req_ack = 1'b0;
        #1;
    endtask

    task automatic set_ack();
        bus.mem_req_ack = 1'b1;
        #1;
    endtask

    // Returns in the LOOKUP cycle (T+1).
    task automatic send(input logic [31:0] addr, input bit we);
        int n = 0;
        while (!bus.cpu_req_ready && n < 20) begin
            tick();
            n++;
        end
        `CHK("send", "_ready", bus.cpu_req_ready, 1)
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = addr;
        bus.cpu_req_we    = we;
        tick();
        bus.cpu_req_valid = 1'b0;
    endtask

    task automatic do_hit(input string nm, input logic [31:0] addr, input bit we,
                          input logic [1:0] way);
        logic [5:0] idx;
        idx             = addr[11:6];
        bus.tag_hit     = 1'b1;
        bus.tag_hit_way = way;
        send(addr, we);
        `CHK(nm, "_lk_rd", bus.tag_rd_en, 1)
        `CHK(nm, "_lk_idx", bus.tag_index, idx)
        tick();
        `CHK(nm, "_cmp_resp", bus.cpu_resp_valid, 0)
        `CHK(nm, "_cmp_tagwr", bus.tag_wr_en, we)
        `CHK(nm, "_cmp_dwe", bus.data_we, we)
        `CHK(nm, "_cmp_mem", bus.mem_req_valid, 0)
        if (we) begin
            `CHK(nm, "_cmp_way", bus.tag_way, way)
            `CHK(nm, "_cmp_dirty", bus.tag_wr_dirty, 1)
            `CHK(nm, "_cmp_fill", bus.data_fill, 0)
            `CHK(nm, "_cmp_dway", bus.data_way, way)
        end
        tick();
        `CHK(nm, "_resp_v", bus.cpu_resp_valid, 1)
        `CHK(nm, "_resp_hit", bus.cpu_resp_hit, 1)
        `CHK(nm, "_resp_mem", bus.mem_req_valid, 0)
        tick();
        `CHK(nm, "_post_v", bus.cpu_resp_valid, 0)
        `CHK(nm, "_post_rdy", bus.cpu_req_ready, 1)
        bus.tag_hit = 1'b0;
    endtask

    // wlat = 0 means a clean victim; otherwise writeback waits wlat cycles for ack.
    task automatic do_miss(input string nm, input logic [31:0] addr, input bit we,
                           input int wlat, input logic [19:0] vtag, input int rlat,
                           input logic [1:0] exp_way);
        logic [5:0]  idx;
        logic [19:0] tg;
        idx                  = addr[11:6];
        tg                   = addr[31:12];
        bus.tag_hit          = 1'b0;
        bus.tag_victim_dirty = (wlat > 0);
        bus.tag_victim_tag   = vtag;
        send(addr, we);
        `CHK(nm, "_lk_rd", bus.tag_rd_en, 1)
        `CHK(nm, "_lk_way", bus.tag_way, exp_way)
        `CHK(nm, "_lk_idx", bus.tag_index, idx)
        `CHK(nm, "_lk_tag", bus.tag_tag, tg)
        tick();
        `CHK(nm, "_cmp_mem", bus.mem_req_valid, 0)
        tick();
        for (int i = 1; i <= wlat; i++) begin
            `CHK(nm, "_wb_v", bus.mem_req_valid, 1)
            `CHK(nm, "_wb_we", bus.mem_req_we, 1)
            `CHK(nm, "_wb_addr", bus.mem_req_addr, {vtag, idx, 6'b0})
            if (i == wlat) set_ack();
            tick();
        end
        for (int i = 1; i <= rlat; i++) begin
            `CHK(nm, "_rf_v", bus.mem_req_valid, 1)
            `CHK(nm, "_rf_we", bus.mem_req_we, 0)
            `CHK(nm, "_rf_addr", bus.mem_req_addr, {tg, idx, 6'b0})
            `CHK(nm, "_rf_dwe0", bus.data_we, 0)
            if (i == rlat) begin
                set_ack();
                `CHK(nm, "_rf_dwe", bus.data_we, 1)
                `CHK(nm, "_rf_fill", bus.data_fill, 1)
                `CHK(nm, "_rf_dway", bus.data_way, exp_way)
                `CHK(nm, "_rf_didx", bus.data_index, idx)
            end
            tick();
        end
        `CHK(nm, "_up_twe", bus.tag_wr_en, 1)
        `CHK(nm, "_up_way", bus.tag_way, exp_way)
        `CHK(nm, "_up_dirty", bus.tag_wr_dirty, we)
        `CHK(nm, "_up_dwe", bus.data_we, we)
        `CHK(nm, "_up_mem", bus.mem_req_valid, 0)
        `CHK(nm, "_up_resp", bus.cpu_resp_valid, 0)
        tick();
        `CHK(nm, "_resp_v", bus.cpu_resp_valid, 1)
        `CHK(nm, "_resp_hit", bus.cpu_resp_hit, 0)
        tick();
        `CHK(nm, "_post_v", bus.cpu_resp_valid, 0)
        `CHK(nm, "_post_rdy", bus.cpu_req_ready, 1)
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts, resps, pending, viol, wcnt, lat;
        bit done, last_resp;

`ifdef CACHE_CTRL_PLRU_EN
        fill_way[0] = 2'd0; fill_way[1] = 2'd2; fill_way[2] = 2'd1; fill_way[3] = 2'd3;
        final_way   = 2'd2;
`else
        fill_way[0] = 2'd0; fill_way[1] = 2'd1; fill_way[2] = 2'd2; fill_way[3] = 2'd3;
        final_way   = 2'd0;
`endif

        rst_n                = 1'b0;
        bus.cpu_req_valid    = 1'b0;
        bus.cpu_req_we       = 1'b0;
        bus.cpu_req_addr     = '0;
        bus.tag_hit          = 1'b0;
        bus.tag_hit_way      = '0;
        bus.tag_victim_dirty = 1'b0;
        bus.tag_victim_tag   = '0;
        bus.mem_req_ack      = 1'b0;

        repeat (2) tick();
        checks++;
        if (bus.cpu_req_ready !== 1'b0) begin
            failures++;
            $error("FAIL rst_ready got=%0b", bus.cpu_req_ready);
        end
        checks++;
        if (bus.cpu_resp_valid !== 1'b0) begin
            failures++;
            $error("FAIL rst_resp got=%0b", bus.cpu_resp_valid);
        end
        checks++;
        if (bus.tag_rd_en !== 1'b0) begin
            failures++;
            $error("FAIL rst_rd got=%0b", bus.tag_rd_en);
        end
        checks++;
        if (bus.tag_wr_en !== 1'b0) begin
            failures++;
            $error("FAIL rst_twe got=%0b", bus.tag_wr_en);
        end
        checks++;
        if (bus.data_we !== 1'b0) begin
            failures++;
            $error("FAIL rst_dwe got=%0b", bus.data_we);
        end
        checks++;
        if (bus.mem_req_valid !== 1'b0) begin
            failures++;
            $error("FAIL rst_mem got=%0b", bus.mem_req_valid);
        end
        checks++;
        if (bus.mem_req_addr !== 32'h0) begin
            failures++;
            $error("FAIL rst_maddr got=%0h", bus.mem_req_addr);
        end
        checks++;
        if (bus.tag_index !== 6'd0) begin
            failures++;
            $error("FAIL rst_tidx got=%0h", bus.tag_index);
        end
        checks++;
        if (bus.tag_way !== 2'd0) begin
            failures++;
            $error("FAIL rst_tway got=%0h", bus.tag_way);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.cpu_req_ready !== 1'b1) begin
            failures++;
            $error("FAIL idle_ready got=%0b", bus.cpu_req_ready);
        end

        do_miss("cold", 32'h0000_1040, 1'b0, 0, 20'h0, 2, 2'd0);
        do_hit("hitld", 32'h0000_1040, 1'b0, 2'd0);
        do_hit("sthit", 32'h0000_2080, 1'b1, 2'd2);
        do_miss("dirty", 32'h0003_3140, 1'b0, 4, 20'h0002A, 1, 2'd0);

        for (int i = 0; i < 4; i++) begin
            do_miss("fill", 32'h0001_0000 + 32'(i) * 32'h1000, 1'b0, 0, 20'h0, 1 + i % 3,
                    fill_way[i]);
        end
        do_hit("hitw0", 32'h0001_0000, 1'b0, 2'd0);
        do_miss("evict", 32'h0001_4000, 1'b0, 0, 20'h0, 1, final_way);

        bus.tag_victim_dirty = 1'b0;
        send(32'h0004_40C0, 1'b0);
        tick();
        tick();
        checks++;
        if (bus.mem_req_valid !== 1'b1) begin
            failures++;
            $error("FAIL rstmid_refill got=%0b", bus.mem_req_valid);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.mem_req_valid !== 1'b0) begin
            failures++;
            $error("FAIL rstmid_mem got=%0b", bus.mem_req_valid);
        end
        checks++;
        if (bus.cpu_resp_valid !== 1'b0) begin
            failures++;
            $error("FAIL rstmid_resp got=%0b", bus.cpu_resp_valid);
        end
        checks++;
        if (bus.cpu_req_ready !== 1'b0) begin
            failures++;
            $error("FAIL rstmid_ready got=%0b", bus.cpu_req_ready);
        end
        tick();
        checks++;
        if (bus.cpu_resp_valid !== 1'b0) begin
            failures++;
            $error("FAIL rstmid_resp2 got=%0b", bus.cpu_resp_valid);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.cpu_req_ready !== 1'b1) begin
            failures++;
            $error("FAIL rstmid_ready2 got=%0b", bus.cpu_req_ready);
        end
        checks++;
        if (bus.cpu_resp_valid !== 1'b0) begin
            failures++;
            $error("FAIL rstmid_resp3 got=%0b", bus.cpu_resp_valid);
        end
        checks++;
        if (bus.mem_req_valid !== 1'b0) begin
            failures++;
            $error("FAIL rstmid_mem2 got=%0b", bus.mem_req_valid);
        end
        do_miss("postrst", 32'h0005_5000, 1'b0, 0, 20'h0, 2, 2'd0);

        accepts   = 0;
        resps     = 0;
        pending   = 0;
        viol      = 0;
        wcnt      = 0;
        lat       = 1;
        done      = 1'b0;
        last_resp = 1'b0;
        bus.tag_hit          = 1'b0;
        bus.tag_victim_dirty = 1'b0;
        bus.cpu_req_addr     = 32'h0000_91C0;
        bus.cpu_req_we       = 1'b0;
        bus.cpu_req_valid    = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            if (bus.mem_req_valid) begin
                if (wcnt == 0) lat = $urandom_range(1, 5);
                wcnt++;
                if (wcnt == lat) begin
                    bus.mem_req_ack = 1'b1;
                    wcnt = 0;
                end
            end
            #1;
            if (last_resp && !bus.cpu_req_ready) viol++;
            last_resp = bus.cpu_resp_valid;
            if (bus.cpu_resp_valid) begin
                if (pending == 0) viol++;
                resps++;
                pending--;
            end
            if (bus.cpu_req_ready) begin
                if (pending != 0) viol++;
                if (accepts < 5) begin
                    accepts++;
                    pending++;
                end else begin
                    bus.cpu_req_valid = 1'b0;
                    done = 1'b1;
                end
            end
            tick();
        end
        bus.cpu_req_valid = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $error("FAIL stream_done got=%0b", done);
        end
        checks++;
        if (resps != 5) begin
            failures++;
            $error("FAIL stream_resps got=%0d", resps);
        end
        checks++;
        if (pending != 0) begin
            failures++;
            $error("FAIL stream_pending got=%0d", pending);
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $error("FAIL stream_viol got=%0d", viol);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Sequencing controller for a set-associative cache. Accepts one CPU request at a time, drives the tag array through lookup and update, and picks a victim way on a miss. Writes back a dirty victim, refills the line from memory, and returns a single-cycle response. Sits between the CPU port and the tag array, data array and memory interface.

## Interface
- ADDR_WIDTH, 32, byte address width
- LINE_SIZE, 64, bytes per line
- NUM_SETS, 64, sets (power of 2)
- ASSOCIATIVITY, 4, ways (power of 2, ≥2)
- Derived: OFF_W=$clog2(LINE_SIZE), SET_W=$clog2(NUM_SETS), WAY_W=$clog2(ASSOCIATIVITY), TAG_W=ADDR_WIDTH-SET_W-OFF_W
- Clock is clk; reset is rst_n, synchronous, active-low.
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- cpu_req_valid  in  1  request present
- cpu_req_ready  out  1  controller can accept a request
- cpu_req_we  in  1  1 = store, 0 = load
- cpu_req_addr  in  ADDR_WIDTH  request address
- cpu_resp_valid  out  1  one-cycle completion pulse
- cpu_resp_hit  out  1  request hit in cache
- tag_rd_en  out  1  lookup strobe
- tag_wr_en  out  1  tag write strobe
- tag_wr_dirty  out  1  write state: 1 = DIRTY, 0 = VALID
- tag_index  out  SET_W  set index
- tag_tag  out  TAG_W  lookup or write tag
- tag_way  out  WAY_W  victim candidate (lookup) or write way
- tag_hit  in  1  lookup hit; valid the cycle after tag_rd_en
- tag_hit_way  in  WAY_W  hitting way
- tag_victim_dirty  in  1  state of the tag_way entry is DIRTY
- tag_victim_tag  in  TAG_W  tag stored in the tag_way entry
- data_we  out  1  data array write strobe
- data_fill  out  1  1 = line refill from memory, 0 = CPU word write
- data_index  out  SET_W; data_way  out  WAY_W  data array target
- mem_req_valid  out  1  memory line request
- mem_req_we  out  1  1 = writeback, 0 = refill
- mem_req_addr  out  ADDR_WIDTH  line-aligned address (offset bits = 0)
- mem_req_ack  in  1  one-cycle line-transfer completion

## Operation
- States: IDLE, LOOKUP, COMPARE, WRITEBACK, REFILL, UPDATE, RESP.
- IDLE:
  - cpu_req_ready=1.
  - When cpu_req_valid=1, latch addr and we, compute the victim for the request's set, then go to LOOKUP.
- LOOKUP:
  - tag_rd_en=1; tag_index, tag_tag and tag_way=victim are driven from the latched values.
  - Go to COMPARE.
- COMPARE, on tag_hit=1:
  - Touch the replacement state for tag_hit_way.
  - For a store: tag_wr_en=1, tag_way=hit_way, tag_wr_dirty=1; data_we=1, data_fill=0.
  - Go to RESP with hit=1.
- COMPARE, on a miss:
  - Latch tag_victim_dirty and tag_victim_tag.
  - Go to WRITEBACK if the victim is dirty, else REFILL.
- WRITEBACK:
  - mem_req_valid=1, mem_req_we=1, mem_req_addr={victim_tag,index,0}.
  - On mem_req_ack, go to REFILL.
- REFILL:
  - mem_req_valid=1, mem_req_we=0, mem_req_addr={req_tag,index,0}.
  - On mem_req_ack: data_we=1, data_fill=1, data_way=victim; go to UPDATE.
- UPDATE:
  - tag_wr_en=1, tag_way=victim, tag_wr_dirty=req_we.
  - For a store: data_we=1, data_fill=0.
  - Touch the replacement state for victim; go to RESP with hit=0.
- RESP: cpu_resp_valid=1 and cpu_resp_hit=the latched hit flag; go to IDLE.
- Strobes not listed for a state are 0. tag_*, data_* and mem_req_addr hold their last values when idle.
- mem_req_* stay stable while mem_req_valid=1 until ack. An ack while mem_req_valid=0 is ignored.
- The victim is latched once per request and does not change even if replacement state updates during the request.
- Reset values: all strobes 0, cpu_req_ready 0 during reset and 1 afterwards, cpu_resp_valid 0, addresses and ways 0, replacement state 0 for every set, state IDLE.
- Reset mid-request abandons the request. mem_req_valid drops in the next cycle and no response is issued.

## Timing
- Hit, load or store: acceptance edge T, LOOKUP at T+1, COMPARE at T+2, cpu_resp_valid at T+3.
- Clean miss: REFILL is entered at T+3; UPDATE is the cycle after the ack; RESP follows UPDATE.
- Dirty miss: WRITEBACK is entered at T+3; REFILL starts the cycle after the writeback ack.
- An ack in the same cycle as request entry completes that request, so the minimum memory wait is 1 cycle.
- Back-to-back requests: cpu_req_ready=1 again in the cycle after RESP. Minimum 4 cycles per hit.

## Configuration
- CACHE_CTRL_PLRU_EN defined:
  - Tree pseudo-LRU with ASSOCIATIVITY-1 bits per set.
  - A touch points every node on the path away from the touched way.
  - The victim follows the node pointers from the root.
- Not defined:
  - Round-robin counter of WAY_W bits per set.
  - The victim is the counter value; the counter increments (wrapping) only in UPDATE.
  - Hits do not change it.

## Structure
- Package cache_pkg:
  - ctrl_state_e enum.
  - Width-derivation functions (SET_W, WAY_W, TAG_W from the parameters).
  - Line-address build helper.
- Sub-module cache_repl holds the per-set replacement state. Its ports are set index in, touch strobe, touch way, and victim way out; the macro selects its implementation inside.

## Test plan
- Cold load to 0x0000_1040 (set 1): miss with victim clean, one refill request to 0x0000_1040, UPDATE with tag_wr_dirty=0, then response with hit=0. A second load to the same address responds hit=1 three cycles after acceptance.
- Store hit on way 2: tag_wr_en with tag_way=2 and tag_wr_dirty=1, data_we with data_fill=0, response with hit=1 and no memory request.
- Dirty miss with victim tag 0x2A in set 5: writeback to {0x2A,5,0} held for 4 cycles until ack, then a refill request, then response. The mem address stays stable throughout.
- Replacement, PLRU build, 4 ways, set 0: fill ways 0..3 with 4 misses, hit way 0, then miss again. The victim is way 2. Round-robin build: the victim is way 0.
- Assert rst_n=0 during REFILL: mem_req_valid=0 the next cycle, no cpu_resp_valid, replacement state cleared, and a later request is handled normally.
- cpu_req_valid held high continuously with random ack latencies of 1–5 cycles: exactly one response per accepted request and cpu_req_ready=0 from acceptance until after RESP.
